// File: rtl/mem_arbiter.sv
// Arbitrates the shared CHIP-8 byte RAM between VGA scanout, CPU and GPU, one access per cycle.
// Optional VGA starvation guard is compiled in with `define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic [DATA_W-1:0] gpu_rdata,
  output logic              gpu_ack,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_GPU  = 2'd2,
    OWN_VGA  = 2'd3
  } owner_e;

  // s1 owns the command currently on mem_*, s2 owns the access whose data is on mem_rdata
  owner_e              s1_owner_q, s1_owner_d;
  owner_e              s2_owner_q, s2_owner_d;
  owner_e              grant;

  logic                cpu_out_q, cpu_out_d;
  logic                gpu_out_q, gpu_out_d;
  logic                rr_gpu_first_q, rr_gpu_first_d;

  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                cpu_ack_q, cpu_ack_d;
  logic                gpu_ack_q, gpu_ack_d;
  logic                vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   gpu_rdata_q, gpu_rdata_d;
  logic [DATA_W-1:0]   vga_rdata_q, vga_rdata_d;

  logic                cpu_done, gpu_done;
  logic                cpu_elig, gpu_elig;
  logic                rr_any, rr_pick_gpu;
  logic                vga_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                starve_force;
`else
  logic                unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_LIMIT > 0);
`endif

  // A requester whose access completes at this edge may be granted again at this same edge.
  always_comb begin
    cpu_done    = (s2_owner_q == OWN_CPU);
    gpu_done    = (s2_owner_q == OWN_GPU);
    cpu_elig    = cpu_req && (!cpu_out_q || cpu_done);
    gpu_elig    = gpu_req && (!gpu_out_q || gpu_done);
    rr_any      = cpu_elig || gpu_elig;
    rr_pick_gpu = gpu_elig && (!cpu_elig || rr_gpu_first_q);
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  always_comb begin
    starve_force = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    vga_win      = vga_req && !(starve_force && rr_any);
  end
`else
  always_comb begin
    vga_win = vga_req;
  end
`endif

  always_comb begin
    grant = OWN_NONE;
    if (vga_win) begin
      grant = OWN_VGA;
    end else if (rr_any) begin
      grant = rr_pick_gpu ? OWN_GPU : OWN_CPU;
    end
  end

  // Command stage: address/data hold their last values while the bus is idle.
  always_comb begin
    mem_en_d    = (grant != OWN_NONE);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (grant)
      OWN_CPU: begin
        mem_we_d    = cpu_we;
        mem_addr_d  = cpu_addr;
        mem_wdata_d = cpu_wdata;
      end
      OWN_GPU: begin
        mem_we_d    = gpu_we;
        mem_addr_d  = gpu_addr;
        mem_wdata_d = gpu_wdata;
      end
      OWN_VGA: begin
        mem_addr_d  = vga_addr;
      end
      default: begin
        mem_we_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    s1_owner_d     = grant;
    s2_owner_d     = s1_owner_q;

    cpu_out_d      = cpu_out_q;
    gpu_out_d      = gpu_out_q;
    if (cpu_done) cpu_out_d = 1'b0;
    if (gpu_done) gpu_out_d = 1'b0;
    if (grant == OWN_CPU) cpu_out_d = 1'b1;
    if (grant == OWN_GPU) gpu_out_d = 1'b1;

    rr_gpu_first_d = rr_gpu_first_q;
    if (grant == OWN_CPU) rr_gpu_first_d = 1'b1;
    if (grant == OWN_GPU) rr_gpu_first_d = 1'b0;
  end

  // Response stage: capture mem_rdata for whoever owned the access the RAM just performed.
  always_comb begin
    cpu_ack_d   = cpu_done;
    gpu_ack_d   = gpu_done;
    vga_valid_d = (s2_owner_q == OWN_VGA);
    cpu_rdata_d = cpu_done    ? mem_rdata : cpu_rdata_q;
    gpu_rdata_d = gpu_done    ? mem_rdata : gpu_rdata_q;
    vga_rdata_d = vga_valid_d ? mem_rdata : vga_rdata_q;
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant == OWN_CPU || grant == OWN_GPU || !rr_any) begin
      starve_cnt_d = '0;
    end else if (grant == OWN_VGA) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_owner_q     <= OWN_NONE;
      s2_owner_q     <= OWN_NONE;
      cpu_out_q      <= 1'b0;
      gpu_out_q      <= 1'b0;
      rr_gpu_first_q <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_ack_q      <= 1'b0;
      gpu_ack_q      <= 1'b0;
      vga_valid_q    <= 1'b0;
      cpu_rdata_q    <= '0;
      gpu_rdata_q    <= '0;
      vga_rdata_q    <= '0;
    end else begin
      s1_owner_q     <= s1_owner_d;
      s2_owner_q     <= s2_owner_d;
      cpu_out_q      <= cpu_out_d;
      gpu_out_q      <= gpu_out_d;
      rr_gpu_first_q <= rr_gpu_first_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_ack_q      <= cpu_ack_d;
      gpu_ack_q      <= gpu_ack_d;
      vga_valid_q    <= vga_valid_d;
      cpu_rdata_q    <= cpu_rdata_d;
      gpu_rdata_q    <= gpu_rdata_d;
      vga_rdata_q    <= vga_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign gpu_ack   = gpu_ack_q;
  assign vga_valid = vga_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign gpu_rdata = gpu_rdata_q;
  assign vga_rdata = vga_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port synchronous RAM.
// Expectations assume a 2-cycle grant-to-ack latency and CPU-first round-robin after reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, gpu_req, gpu_we, vga_req;
  logic [11:0] cpu_addr, gpu_addr, vga_addr;
  logic [7:0]  cpu_wdata, gpu_wdata;
  logic [7:0]  cpu_rdata, gpu_rdata, vga_rdata;
  logic        cpu_ack, gpu_ack, vga_valid;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        tb_load;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int we0;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  mem_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
    .gpu_rdata(gpu_rdata), .gpu_ack(gpu_ack),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_valid(vga_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (tb_load) begin
      ram[12'h200] <= 8'h6A;
      ram[12'h100] <= 8'h3C;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; gpu_req = 1'b0; vga_req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tb_load = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    gpu_req = 0; gpu_we = 0; gpu_addr = '0; gpu_wdata = '0;
    vga_req = 0; vga_addr = '0;
    step();
    tb_load = 1'b0;
    step();
    reset = 1'b0;

    $display("txn: reset state");
    check("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
    check("rst_rsp", 32'({cpu_ack, gpu_ack, vga_valid, cpu_rdata, gpu_rdata, vga_rdata}), 32'd0);

    // CPU-only read of 0x200
    $display("txn: cpu read 0x200");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    step();
    check("rd_grant", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 12'h200}));
    cpu_req = 1'b0; cpu_addr = 12'hFFF;
    step();
    check("rd_e1", 32'({mem_en, cpu_ack}), 32'd0);
    step();
    check("rd_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, 8'h6A}));
    step();
    check("rd_pulse", 32'(cpu_ack), 32'd0);

    // CPU write 0xA5 to 0x300, then read it back
    $display("txn: cpu write 0x300=a5");
    we0 = we_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'hA5;
    step();
    check("wr_grant", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 12'h300, 8'hA5}));
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    step();
    check("wr_ack", 32'(cpu_ack), 32'd1);
    step();
    $display("txn: cpu read 0x300");
    cpu_req = 1'b1; cpu_addr = 12'h300;
    step();
    cpu_req = 1'b0;
    step();
    step();
    check("rd_back", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, 8'hA5}));
    step();
    check("we_once", 32'(we_cnt - we0), 32'd1);

    // CPU and GPU both requesting every cycle
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 12'h300;
    for (int k = 0; k < 6; k++) begin
      step();
      $display("txn: rr cycle %0d mem_addr=%0h", k, mem_addr);
      check("alt_addr", 32'({mem_en, mem_addr}), 32'({1'b1, ((k % 2) == 1) ? 12'h300 : 12'h200}));
      check("alt_cpu_ack", 32'(cpu_ack), 32'(k >= 2 && (k % 2) == 0));
      check("alt_gpu_ack", 32'(gpu_ack), 32'(k >= 3 && (k % 2) == 1));
      check("alt_cpu_rdata", 32'(cpu_rdata), (k >= 2) ? 32'h6A : 32'h0);
      check("alt_gpu_rdata", 32'(gpu_rdata), (k >= 3) ? 32'hA5 : 32'h0);
    end

    // VGA streaming with a CPU read pending
    do_reset();
    vga_req = 1'b1; vga_addr = 12'h100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    for (int k = 0; k < 20; k++) begin
      step();
      $display("txn: vga cycle %0d mem_addr=%0h cpu_ack=%0d", k, mem_addr, cpu_ack);
      check("starve_addr", 32'({mem_en, mem_we, mem_addr}),
            32'({1'b1, 1'b0, (GUARD && k == 8) ? 12'h200 : 12'h100}));
      check("starve_cpu_ack", 32'(cpu_ack), 32'(GUARD && k == 10));
      check("starve_vga_valid", 32'(vga_valid), 32'(k >= 2 && !(GUARD && k == 10)));
      check("starve_vga_rdata", 32'(vga_rdata), (k >= 2) ? 32'h3C : 32'h0);
      if (k == 8) cpu_req = 1'b0;
    end

    // Reset one cycle after a GPU grant drops the access
    do_reset();
    $display("txn: gpu read 0x300 interrupted by reset");
    gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 12'h300;
    step();
    check("gpu_grant", 32'({mem_en, mem_addr}), 32'({1'b1, 12'h300}));
    gpu_req = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("post_rst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
    check("post_rst_rsp", 32'({cpu_ack, gpu_ack, vga_valid, cpu_rdata, gpu_rdata, vga_rdata}), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("no_gpu_ack", 32'({gpu_ack, mem_en}), 32'd0);
    end
    $display("txn: gpu read 0x300 after reset");
    gpu_req = 1'b1;
    step();
    check("gpu_regrant", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 12'h300}));
    gpu_req = 1'b0;
    step();
    step();
    check("gpu_ack", 32'({gpu_ack, gpu_rdata}), 32'({1'b1, 8'hA5}));

    // Idle bus
    $display("txn: idle bus");
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_mem", 32'({mem_en, mem_we}), 32'd0);
      check("idle_rsp", 32'({cpu_ack, gpu_ack, vga_valid}), 32'd0);
      check("idle_addr_hold", 32'(mem_addr), 32'h300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single 4 KiB CHIP-8 byte memory between three requesters: CPU (read/write), GPU sprite engine (read/write) and VGA scanout (read-only).
- Issues at most one memory access per cycle to a single-port synchronous RAM.
- Fixed priority: VGA is highest; CPU and GPU share the remaining slots round-robin.
- Returns read data and a one-cycle acknowledge to each requester.

Parameters:
- ADDR_W, 12, memory address width
- DATA_W, 8, memory data width
- STARVE_LIMIT, 8, consecutive VGA grants allowed while CPU/GPU wait (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- gpu_req, gpu_we, gpu_addr, gpu_wdata, gpu_rdata, gpu_ack: same widths and semantics as the CPU ports
- vga_req  in  1  VGA read request
- vga_addr  in  ADDR_W  VGA address
- vga_rdata  out  DATA_W  VGA read data
- vga_valid  out  1  one-cycle pulse, vga_rdata valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en

Behaviour:
- Reset (reset=1 at a posedge):
  - all outputs go to 0: mem_*, *_ack, vga_valid, *_rdata
  - round-robin pointer set to CPU-first
  - outstanding flags cleared; in-flight accesses are dropped and produce no ack
- Pipeline:
  - Requests are sampled at posedge P. The winner's command is registered onto mem_* at P.
  - The RAM performs the access at P+1.
  - At P+2 the arbiter registers mem_rdata into the winner's *_rdata and pulses *_ack (or vga_valid) high for exactly one cycle.
  - Reads and writes both take 2 cycles to ack. Throughput is one grant per cycle.
- Eligibility: a requester is eligible when req=1 and it has no outstanding access. Outstanding is set at grant and cleared at the ack posedge.
  - req still high in the ack cycle is treated as a new request, eligible from the following posedge.
  - Back-to-back grants to the same requester therefore occur every 2 cycles at most.
- Priority order:
  1. VGA.
  2. CPU/GPU round-robin: when both are eligible, grant the one not granted last. The pointer updates only on CPU/GPU grants. A single eligible requester wins regardless of the pointer.
- No eligible requester: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.
- mem_we is only ever 1 together with mem_en=1. VGA grants always drive mem_we=0.
- Requester address and data are sampled only at the grant. The requester holds them stable until ack; changes after the grant are ignored.
- Simultaneous CPU and GPU writes to the same address: serialized by round-robin, and the later grant wins.
- The ack order for the requesters matches the grant order.
- Ack and rdata are registered, with no combinational path from req to ack.
- Widths are exact; no address wrap logic. The RAM ignores addresses beyond its size.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN
- With the macro defined:
  - A counter increments on each VGA grant made while CPU or GPU is eligible. It is cleared on any CPU/GPU grant or when neither is eligible.
  - When the counter equals STARVE_LIMIT, the next slot goes to the round-robin CPU/GPU winner even if VGA is requesting.
  - The counter resets to 0 on reset.
- Without the macro: strict VGA priority. CPU/GPU may starve indefinitely. No counter is synthesized.

Test Plan:
- CPU-only read: reset, then cpu_req=1, cpu_we=0, cpu_addr=0x200 with RAM[0x200]=0x6A → mem_en=1 with mem_addr=0x200 one cycle after sampling; cpu_ack pulses 2 cycles after the grant with cpu_rdata=0x6A.
- CPU write then read: write 0xA5 to 0x300, then read 0x300 → second cpu_rdata=0xA5; exactly one mem_we=1 cycle.
- CPU and GPU both request each cycle with no VGA → grants alternate CPU, GPU, CPU, GPU starting with CPU after reset; each requester sees an ack every 2 cycles.
- VGA continuous requests plus pending CPU read:
  - feature off: no cpu_ack for 20 cycles;
  - feature on (STARVE_LIMIT=8): CPU granted after exactly 8 VGA grants.
- Reset asserted one cycle after a GPU grant → no gpu_ack ever appears; all outputs are 0 in the cycle after reset; the first request after reset is granted normally.
- Idle bus: no req for 10 cycles → mem_en=0, mem_we=0 every cycle; no ack or vga_valid pulses.
